// File: rtl/pwm_capture.sv
// Multi-channel PWM duty/period decoder: shared tick prescaler feeding one
// measurement lane per input, each with synchroniser, phase counters and timeout.
module pwm_capture_lane #(
  parameter int RES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           pwm_in,
  output logic [RES-1:0] dc,
  output logic [RES:0]   period,
  output logic           valid,
  output logic           stuck
);
  localparam int W = RES + 1;
  localparam logic [W-1:0]   ONES   = '1;
  localparam logic [RES-1:0] DMAX   = '1;
  localparam logic [W-1:0]   DMAX_W = {1'b0, DMAX};

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t         state_q, state_d;
  logic           s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [W-1:0]   high_q, high_d, low_q, low_d, idle_q, idle_d;
  logic [RES-1:0] dc_q, dc_d;
  logic [W-1:0]   per_q, per_d;
  logic           valid_q, valid_d, stuck_q, stuck_d;

  logic           rise, fall, any_edge, timeout;
  logic [W-1:0]   high_inc, low_inc, idle_inc, low_fin;
  logic [W:0]     sum;

  always_comb begin
    rise     = s2_q & ~s3_q;
    fall     = ~s2_q & s3_q;
    any_edge = rise | fall;
    high_inc = (high_q == ONES) ? high_q : high_q + 1'b1;
    low_inc  = (low_q  == ONES) ? low_q  : low_q  + 1'b1;
    idle_inc = (idle_q == ONES) ? idle_q : idle_q + 1'b1;
    // the tick landing on the closing rise still belongs to the low phase
    low_fin  = tick ? low_inc : low_q;
    sum      = {1'b0, high_q} + {1'b0, low_fin};
    // idle_q at all-ones plus this tick makes 2^W ticks without an edge
    timeout  = tick & (idle_q == ONES) & ~any_edge & (state_q != STUCK);

    s1_d    = pwm_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    idle_d  = any_edge ? '0 : (tick ? idle_inc : idle_q);
    dc_d    = dc_q;
    per_d   = per_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;

    if (timeout) begin
      state_d = STUCK;
      stuck_d = 1'b1;
      dc_d    = s2_q ? DMAX : '0;
      per_d   = '0;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d = HIGH;
          high_d  = '0;
          low_d   = '0;
        end
        HIGH: begin
          if (tick) high_d = high_inc;
          if (fall) state_d = LOW;
        end
        LOW: begin
          if (rise) begin
            dc_d    = (high_q > DMAX_W) ? DMAX : high_q[RES-1:0];
            per_d   = (sum > {1'b0, ONES}) ? ONES : sum[W-1:0];
            valid_d = 1'b1;
            high_d  = '0;
            low_d   = '0;
            state_d = HIGH;
          end else begin
            low_d = low_fin;
          end
        end
        STUCK: begin
          if (rise) begin
            state_d = HIGH;
            high_d  = '0;
            low_d   = '0;
            stuck_d = 1'b0;
          end else if (fall) begin
            state_d = IDLE;
            stuck_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      idle_q  <= '0;
      dc_q    <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      high_q  <= high_d;
      low_q   <= low_d;
      idle_q  <= idle_d;
      dc_q    <= dc_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  assign dc     = dc_q;
  assign period = per_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;
endmodule

module pwm_capture #(
  parameter int SysClk     = 125000000,
  parameter int PWMFreq    = 50,
  parameter int Resolution = 8,
  parameter int NPWM       = 5,
  parameter int TickDiv    = SysClk / (PWMFreq * (2 ** Resolution))
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NPWM-1:0]                PWMIn,
  output logic [NPWM*Resolution-1:0]     DC_bus,
  output logic [NPWM*(Resolution+1)-1:0] Period_bus,
  output logic [NPWM-1:0]                Valid,
  output logic [NPWM-1:0]                Stuck
);
  localparam int CW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TickDiv - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == CMAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NPWM; i++) begin : g_lane
    pwm_capture_lane #(.RES(Resolution)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .pwm_in (PWMIn[i]),
      .dc     (DC_bus[i*Resolution +: Resolution]),
      .period (Period_bus[i*(Resolution+1) +: Resolution+1]),
      .valid  (Valid[i]),
      .stuck  (Stuck[i])
    );
  end
endmodule
